// File: rtl/mavg_pkg.sv
//----------------------------------------------------------------------------
// Module : mavg_pkg
// Brief  : Shared widths, types and rounding helper for the moving-average
//          channel scheduler.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package mavg_pkg;

    localparam int TAPS     = 4;
    localparam int SAMPLE_W = 8;
    localparam int SUM_W    = 10;
    localparam int ROUND    = 2;
    localparam int SHIFT    = $clog2(TAPS);

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [SUM_W-1:0]    sum_t;
    // Element 0 is the most recent stored sample.
    typedef sample_t [TAPS-2:0]  hist_t;

    function automatic sample_t round_avg(input sum_t s);
        sum_t t;
        t = s + sum_t'(ROUND);
        return t[SHIFT +: SAMPLE_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mavg_channel_scheduler_rr_arbiter.sv
//----------------------------------------------------------------------------
// Module : rr_arbiter
// Brief  : Combinational rotating-priority arbiter; ptr holds top priority.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [CW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] idx
);

    logic [CW:0] w_pos;

    // Scan from farthest to nearest so the nearest requester wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        w_pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = {1'b0, ptr} + (CW+1)'(k);
            if (w_pos >= (CW+1)'(N)) begin
                w_pos = w_pos - (CW+1)'(N);
            end
            if (en && req[w_pos[CW-1:0]]) begin
                grant                 = '0;
                grant[w_pos[CW-1:0]]  = 1'b1;
                idx                   = w_pos[CW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mavg_channel_scheduler.sv
//----------------------------------------------------------------------------
// Module : mavg_channel_scheduler
// Brief  : One shared 4-tap rounded moving average, round-robin time-shared
//          among N channels. Optional MAVG_WARMUP_EN suppresses output until
//          a channel has three stored samples.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module mavg_channel_scheduler
    import mavg_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic            ck,
    input  logic            r,
    input  logic [N-1:0]    req,
    input  logic [N*8-1:0]  x,
    input  logic [N-1:0]    clr,
    output logic [N-1:0]    ack,
    output logic [7:0]      y,
    output logic [CW-1:0]   y_ch,
    output logic            y_valid,
    input  logic            y_ready
);

    logic [CW-1:0] r_ptr;
    hist_t         r_hist [N];
    sample_t       r_y;
    logic [CW-1:0] r_ych;
    logic          r_yv;

    logic          w_en;
    logic [N-1:0]  w_grant;
    logic [CW-1:0] w_gidx;
    logic          w_xfer;
    logic          w_emit;
    sample_t       w_xg;
    hist_t         w_hg;
    logic          w_clr_g;
    sum_t          w_sum;
    sample_t       w_avg;

    assign w_en = (~r_yv | y_ready) & ~r;

    rr_arbiter #(.N(N), .CW(CW)) u_arb (
        .req   (req),
        .en    (w_en),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_gidx)
    );

    assign ack    = w_grant;
    assign w_xfer = |w_grant;

    always_comb begin
        w_xg    = '0;
        w_hg    = '0;
        w_clr_g = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_gidx == CW'(i)) begin
                w_xg    = x[i*SAMPLE_W +: SAMPLE_W];
                w_hg    = r_hist[i];
                w_clr_g = clr[i];
            end
        end
    end

    // A same-edge clear makes the window see an all-zero history.
    always_comb begin
        w_sum = sum_t'(w_xg);
        if (!w_clr_g) begin
            for (int t = 0; t < TAPS - 1; t++) begin
                w_sum = w_sum + sum_t'(w_hg[t]);
            end
        end
    end

    assign w_avg = round_avg(w_sum);

`ifdef MAVG_WARMUP_EN
    logic [1:0] r_fill [N];
    logic [1:0] w_fill_g;

    always_comb begin
        w_fill_g = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gidx == CW'(i)) begin
                w_fill_g = r_fill[i];
            end
        end
    end

    assign w_emit = w_xfer & ~w_clr_g & (w_fill_g == 2'd3);

    always_ff @(posedge ck or posedge r) begin
        if (r) begin
            for (int i = 0; i < N; i++) begin
                r_fill[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_grant[i]) begin
                    if (clr[i]) begin
                        r_fill[i] <= 2'd1;
                    end else if (r_fill[i] != 2'd3) begin
                        r_fill[i] <= r_fill[i] + 2'd1;
                    end
                end else if (clr[i]) begin
                    r_fill[i] <= 2'd0;
                end
            end
        end
    end
`else
    assign w_emit = w_xfer;
`endif

    always_ff @(posedge ck or posedge r) begin
        if (r) begin
            for (int i = 0; i < N; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_grant[i]) begin
                    r_hist[i] <= clr[i] ? hist_t'(x[i*SAMPLE_W +: SAMPLE_W])
                                        : {r_hist[i][TAPS-3:0], x[i*SAMPLE_W +: SAMPLE_W]};
                end else if (clr[i]) begin
                    r_hist[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge ck or posedge r) begin
        if (r) begin
            r_ptr <= '0;
            r_y   <= '0;
            r_ych <= '0;
            r_yv  <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_ptr <= (w_gidx == CW'(N - 1)) ? '0 : w_gidx + CW'(1);
            end
            if (w_emit) begin
                r_y   <= w_avg;
                r_ych <= w_gidx;
                r_yv  <= 1'b1;
            end else if (y_ready) begin
                r_yv  <= 1'b0;
            end
        end
    end

    assign y       = r_y;
    assign y_ch    = r_ych;
    assign y_valid = r_yv;

endmodule

`default_nettype wire

// File: tb/tb_mavg_channel_scheduler.sv
//----------------------------------------------------------------------------
// Module : tb_mavg_channel_scheduler
// Brief  : Table-driven self-checking bench with a result scoreboard.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_mavg_channel_scheduler;

    logic        ck = 1'b0;
    logic        r;
    logic [3:0]  req;
    logic [31:0] x;
    logic [3:0]  clr;
    logic [3:0]  ack;
    logic [7:0]  y;
    logic [1:0]  y_ch;
    logic        y_valid;
    logic        y_ready;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] x;
        logic [3:0]  clr;
        logic        rdy;
        logic [3:0]  ack;
        logic        emit;
        logic [7:0]  y;
        logic [1:0]  ch;
        logic        v;
    } vec_t;

    vec_t       tbl [$];
    logic [9:0] sb  [$];

    mavg_channel_scheduler #(.N(4), .CW(2)) dut (
        .ck      (ck),
        .r       (r),
        .req     (req),
        .x       (x),
        .clr     (clr),
        .ack     (ack),
        .y       (y),
        .y_ch    (y_ch),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    always #5 ck = ~ck;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] rq, input logic [31:0] xv,
                                input logic [3:0] cl, input logic rd,
                                input logic [3:0] ak, input logic em,
                                input logic [7:0] ey, input logic [1:0] ec,
                                input logic ev);
        tbl.push_back('{rq, xv, cl, rd, ak, em, ey, ec, ev});
    endfunction

    // Called just after a rising edge; leaves time just after the next one.
    task automatic step(input vec_t v, input int n);
        logic [9:0] e;
        req     = v.req;
        x       = v.x;
        clr     = v.clr;
        y_ready = v.rdy;
        @(negedge ck);
        chk($sformatf("v%0d_ack", n), 32'(ack), 32'(v.ack));
        if (v.emit) sb.push_back({v.y, v.ch});
        @(posedge ck);
        #1;
        chk($sformatf("v%0d_valid", n), 32'(y_valid), 32'(v.v));
        if (v.emit) begin
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", n), 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_y", n), 32'(y), 32'(e[9:2]));
                chk($sformatf("v%0d_ych", n), 32'(y_ch), 32'(e[1:0]));
            end
        end else begin
            chk($sformatf("v%0d_y_hold", n), 32'(y), 32'(v.y));
            chk($sformatf("v%0d_ych_hold", n), 32'(y_ch), 32'(v.ch));
        end
    endtask

    initial begin
        r       = 1'b1;
        req     = 4'hF;
        x       = '0;
        clr     = '0;
        y_ready = 1'b1;
        #3;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_valid", 32'(y_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_ych", 32'(y_ch), 32'd0);
        req = '0;
        @(negedge ck);
        r = 1'b0;
        @(posedge ck);
        #1;

`ifdef MAVG_WARMUP_EN
        add(4'b0001, {8'd0, 8'd0, 8'd0, 8'd4}, 4'b0000, 1, 4'b0001, 0, 8'd0, 2'd0, 0);
        add(4'b0001, {8'd0, 8'd0, 8'd0, 8'd4}, 4'b0000, 1, 4'b0001, 0, 8'd0, 2'd0, 0);
        add(4'b0001, {8'd0, 8'd0, 8'd0, 8'd4}, 4'b0000, 1, 4'b0001, 0, 8'd0, 2'd0, 0);
        add(4'b0001, {8'd0, 8'd0, 8'd0, 8'd4}, 4'b0000, 1, 4'b0001, 1, 8'd4, 2'd0, 1);
        add(4'b0001, {8'd0, 8'd0, 8'd0, 8'd8}, 4'b0001, 1, 4'b0001, 0, 8'd4, 2'd0, 0);
`else
        // Single transfer, then a four-sample ramp on channel 1.
        add(4'b0001, {8'd0, 8'd0, 8'd0, 8'd100}, 4'b0000, 1, 4'b0001, 1, 8'd25, 2'd0, 1);
        add(4'b0010, {8'd0, 8'd0, 8'd10, 8'd0},  4'b0000, 1, 4'b0010, 1, 8'd3,  2'd1, 1);
        add(4'b0010, {8'd0, 8'd0, 8'd20, 8'd0},  4'b0000, 1, 4'b0010, 1, 8'd8,  2'd1, 1);
        add(4'b0010, {8'd0, 8'd0, 8'd30, 8'd0},  4'b0000, 1, 4'b0010, 1, 8'd15, 2'd1, 1);
        add(4'b0010, {8'd0, 8'd0, 8'd40, 8'd0},  4'b0000, 1, 4'b0010, 1, 8'd25, 2'd1, 1);
        add(4'b0000, 32'd0,                      4'b0000, 1, 4'b0000, 0, 8'd25, 2'd1, 0);
        add(4'b1000, 32'd0,                      4'b0000, 1, 4'b1000, 1, 8'd0,  2'd3, 1);
        // All channels requesting: rotation 0,1,2,3,0.
        add(4'b1111, {8'd16, 8'd12, 8'd8, 8'd4}, 4'b0000, 1, 4'b0001, 1, 8'd26, 2'd0, 1);
        add(4'b1111, {8'd16, 8'd12, 8'd8, 8'd4}, 4'b0000, 1, 4'b0010, 1, 8'd25, 2'd1, 1);
        add(4'b1111, {8'd16, 8'd12, 8'd8, 8'd4}, 4'b0000, 1, 4'b0100, 1, 8'd3,  2'd2, 1);
        add(4'b1111, {8'd16, 8'd12, 8'd8, 8'd4}, 4'b0000, 1, 4'b1000, 1, 8'd4,  2'd3, 1);
        add(4'b1111, {8'd16, 8'd12, 8'd8, 8'd4}, 4'b0000, 1, 4'b0001, 1, 8'd27, 2'd0, 1);
        // Backpressure for five cycles, then release.
        for (int i = 0; i < 5; i++)
            add(4'b0100, {8'd0, 8'd200, 8'd0, 8'd0}, 4'b0000, 0, 4'b0000, 0, 8'd27, 2'd0, 1);
        add(4'b0100, {8'd0, 8'd200, 8'd0, 8'd0}, 4'b0000, 1, 4'b0100, 1, 8'd53,  2'd2, 1);
        add(4'b0100, {8'd0, 8'd200, 8'd0, 8'd0}, 4'b0000, 1, 4'b0100, 1, 8'd103, 2'd2, 1);
        add(4'b0100, {8'd0, 8'd200, 8'd0, 8'd0}, 4'b0000, 1, 4'b0100, 1, 8'd153, 2'd2, 1);
        // Clear with a same-edge transfer, then clear alone.
        add(4'b0100, {8'd0, 8'd255, 8'd0, 8'd0}, 4'b0100, 1, 4'b0100, 1, 8'd64, 2'd2, 1);
        add(4'b0100, {8'd0, 8'd1, 8'd0, 8'd0},   4'b0000, 1, 4'b0100, 1, 8'd64, 2'd2, 1);
        add(4'b0000, 32'd0,                      4'b0010, 1, 4'b0000, 0, 8'd64, 2'd2, 0);
        add(4'b0010, {8'd0, 8'd0, 8'd4, 8'd0},   4'b0000, 1, 4'b0010, 1, 8'd1,  2'd1, 1);
`endif

        foreach (tbl[i]) step(tbl[i], i);

`ifndef MAVG_WARMUP_EN
        // Asynchronous reset between edges while a result is pending.
        chk("pre_rst_valid", 32'(y_valid), 32'd1);
        req = 4'hF;
        clr = '0;
        #2;
        r = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_valid", 32'(y_valid), 32'd0);
        chk("mid_rst_y", 32'(y), 32'd0);
        chk("mid_rst_ych", 32'(y_ch), 32'd0);
        req = '0;
        @(negedge ck);
        r = 1'b0;
        @(posedge ck);
        #1;
        chk("post_rst_valid", 32'(y_valid), 32'd0);
        step('{4'b1000, {8'd4, 8'd0, 8'd0, 8'd0}, 4'b0000, 1'b1, 4'b1000, 1'b1, 8'd1, 2'd3, 1'b1}, 100);
        step('{4'b1111, {8'd4, 8'd4, 8'd4, 8'd8}, 4'b0000, 1'b1, 4'b0001, 1'b1, 8'd2, 2'd0, 1'b1}, 101);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
